fifo_byte_drain: RTL and testbench
==================================

# fifo_byte_drain

Downstream consumer of the word FIFO. Pops one `data_width`-bit word at a time from the FIFO read port and streams it out as bytes over a valid/ready byte interface feeding the serial/bus transmitter. Supports zero-bubble back-to-back words, a synchronous flush, and a running count of completed words.

## Interface
- `data_width`, 32, FIFO word width; must be a multiple of 8 and at least 8.
- `msb_first`, 1, 1 = most significant byte sent first; 0 = least significant byte sent first.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset; asynchronous, active-low.
- `fifo_data`  in  data_width  FIFO head word (FIFO `data_out`); valid whenever `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_next`  out  1  Pop strobe to FIFO `next`; combinational; each high cycle pops exactly one word.
- `flush`  in  1  Synchronous abort of the word in progress.
- `byte_out`  out  8  Current byte; registered.
- `byte_valid`  out  1  `byte_out` is valid; registered.
- `byte_ready`  in  1  Sink accepts `byte_out` this cycle when high together with `byte_valid`.
- `busy`  out  1  High while a word is held (state SEND).
- `words_sent`  out  16  Count of fully transmitted words; wraps 0xFFFF -> 0x0000.

## Operation
- NB = `data_width`/8 bytes per word. Internal state: `shift` (data_width), byte index `idx` (ceil(log2(NB+1)) bits), and state IDLE/SEND.
- IDLE:
  - `fifo_next` = !`fifo_empty` && !`flush`.
  - When `fifo_next` is high at the edge: latch `fifo_data` into `shift`, `idx`<=0, go to SEND, `byte_valid`<=1, `byte_out`<=first byte.
  - First byte = `fifo_data[data_width-1 -: 8]` if `msb_first`, else `fifo_data[7:0]`.
- SEND, handshake (`byte_valid` && `byte_ready`), not last byte (`idx` < NB-1):
  - `idx`++.
  - `byte_out`<=next byte (shift left 8 if `msb_first`, else right 8).
- SEND, handshake on last byte (`idx`==NB-1):
  - `words_sent`++.
  - If !`fifo_empty` && !`flush`: `fifo_next`=1 this cycle, load new word exactly as in IDLE, stay in SEND, `byte_valid` stays 1 (zero-bubble).
  - Otherwise: go to IDLE, `byte_valid`<=0.
- SEND, no handshake: hold `byte_out`, `byte_valid`, and `idx`. `byte_out` must not change while `byte_valid` is high and `byte_ready` is low.
- `fifo_next` in SEND is high only on the last-byte handshake with a non-empty FIFO. It is never high in any other SEND cycle.
- `flush` (any state) has priority over everything:
  - Go to IDLE, `byte_valid`<=0, `idx`<=0.
  - `fifo_next`=0 that cycle. `words_sent` unchanged, even if a last-byte handshake coincides.
  - A byte handshaking in the same cycle as `flush` is considered dropped.
- `busy` = (state==SEND).
- NB==1: every handshake is a last-byte handshake.

## Timing
- Reset values (asynchronous on `rst_n` low): state IDLE, `byte_valid`=0, `byte_out`=0x00, `busy`=0, `words_sent`=0, `idx`=0, `shift`=0. `fifo_next`=0 while in reset.
- Reset mid-word: the word in progress is discarded; it was already popped from the FIFO.
- Latency: FIFO non-empty at edge N (IDLE) -> `byte_valid`=1 after edge N.
- Throughput: with `byte_ready` held high, one byte per cycle and NB cycles per word, with no idle cycles between consecutive words.
- `fifo_next` depends combinationally on `fifo_empty`, `flush`, `byte_ready`, and state. There is no path from `fifo_data` to `fifo_next`.
- `words_sent` updates on the edge of the last-byte handshake.

## Test plan
- Reset, then FIFO holds one word 0xA1B2C3D4, `msb_first`=1, `byte_ready`=1 -> exactly one `fifo_next` pulse; bytes A1,B2,C3,D4 on 4 consecutive cycles; then `byte_valid`=0, `busy`=0, `words_sent`=1.
- `msb_first`=0, same word -> bytes D4,C3,B2,A1.
- Two words 0x11223344, 0x55667788 queued, `byte_ready`=1 -> 8 consecutive valid bytes with no gap; `fifo_next` high only in the IDLE cycle and in the cycle byte 44 is accepted; `words_sent`=2.
- Backpressure: `byte_ready` low for 3 cycles while B2 is presented -> `byte_out` holds 0xB2 with `byte_valid`=1 throughout; sequence resumes with C3 once `byte_ready` returns high; no extra pops.
- `flush` asserted while C3 is presented -> next cycle `byte_valid`=0 and state IDLE; `words_sent` unchanged; no `fifo_next` during the flush cycle; the following queued word then streams from its first byte.
- `rst_n` pulsed low asynchronously mid-word (between edges) -> `byte_valid`, `busy`, `byte_out`, and `words_sent` go to 0 immediately; after release, the next queued word streams normally.

Source files
------------

// File: rtl/fifo_byte_drain.sv
// Pops words from the word FIFO and streams them out as bytes over valid/ready.
// Back-to-back words chain without a bubble; flush drops the word in progress.
module fifo_byte_drain #(
    parameter int data_width = 32,   // multiple of 8, at least 8
    parameter bit msb_first  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_next,
    input  logic                  flush,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  busy,
    output logic [15:0]           words_sent
);

    localparam int NB = data_width / 8;
    localparam int IW = $clog2(NB + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state;
    logic [data_width-1:0] shift;
    logic [data_width-1:0] shift_adv;
    logic [IW-1:0]         idx;
    logic                  hs;
    logic                  last;
    logic                  load;

    function automatic logic [7:0] head_byte(input logic [data_width-1:0] w);
        return msb_first ? w[data_width-1 -: 8] : w[7:0];
    endfunction

    assign hs        = byte_valid && byte_ready;
    assign last      = (idx == IW'(NB - 1));
    // In SEND a new word is only taken as the last byte leaves, so the
    // pop strobe never depends on the data itself.
    assign load      = !fifo_empty && !flush && (state == IDLE || (hs && last));
    assign fifo_next = rst_n && load;
    assign shift_adv = msb_first ? (shift << 8) : (shift >> 8);
    assign busy      = (state == SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            idx        <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            words_sent <= 16'h0000;
        end else if (flush) begin
            state      <= IDLE;
            byte_valid <= 1'b0;
            idx        <= '0;
        end else if (load) begin
            shift      <= fifo_data;
            idx        <= '0;
            state      <= SEND;
            byte_valid <= 1'b1;
            byte_out   <= head_byte(fifo_data);
            if (state == SEND)
                words_sent <= words_sent + 16'd1;
        end else if (state == SEND && hs) begin
            if (last) begin
                words_sent <= words_sent + 16'd1;
                state      <= IDLE;
                byte_valid <= 1'b0;
            end else begin
                idx      <= idx + IW'(1);
                shift    <= shift_adv;
                byte_out <= head_byte(shift_adv);
            end
        end
    end

endmodule

// File: tb/tb_fifo_byte_drain.sv
// Bench for fifo_byte_drain: MSB- and LSB-first instances share one stimulus,
// checked every cycle against a word/byte-index model plus literal byte logs.
module tb_fifo_byte_drain;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        flush;
    logic        byte_ready;
    logic        next_m, next_l;
    logic [7:0]  out_m, out_l;
    logic        vld_m, vld_l, busy_m, busy_l;
    logic [15:0] ws_m, ws_l;

    fifo_byte_drain #(.data_width(32), .msb_first(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_next(next_m), .flush(flush), .byte_out(out_m), .byte_valid(vld_m),
        .byte_ready(byte_ready), .busy(busy_m), .words_sent(ws_m));

    fifo_byte_drain #(.data_width(32), .msb_first(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_next(next_l), .flush(flush), .byte_out(out_l), .byte_valid(vld_l),
        .byte_ready(byte_ready), .busy(busy_l), .words_sent(ws_l));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // simple source FIFO, popped by the MSB instance
    logic [31:0] fifo_mem [16];
    int rd = 0;
    int wr = 0;
    int dut_pops = 0;
    always_comb begin
        fifo_data  = fifo_mem[rd & 15];
        fifo_empty = (rd == wr);
    end
    always @(posedge clk) if (next_m) begin rd <= rd + 1; dut_pops <= dut_pops + 1; end

    task automatic push(input logic [31:0] w);
        fifo_mem[wr & 15] = w;
        wr++;
    endtask

    // model: the word being sent and how many of its bytes have gone
    logic [31:0] m_word = '0;
    bit          m_have = 0;
    int          m_k = 0;
    int          m_words = 0;
    logic [7:0]  log_m [$];
    logic [7:0]  log_l [$];

    function automatic bit exp_next();
        return rst_n && !flush && !fifo_empty && (!m_have || (byte_ready && m_k == NB - 1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have  = 0;
            m_k     = 0;
            m_words = 0;
        end else begin
            automatic bit nx = exp_next();
            if (vld_m && byte_ready && !flush) begin
                log_m.push_back(out_m);
                log_l.push_back(out_l);
            end
            if (flush) begin
                m_have = 0;
                m_k    = 0;
            end else if (m_have && byte_ready) begin
                m_k++;
                if (m_k == NB) begin
                    m_have = 0;
                    m_words++;
                end
            end
            if (nx) begin
                m_word = fifo_data;
                m_have = 1;
                m_k    = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid_msb", {31'd0, vld_m}, {31'd0, m_have});
        chk("valid_lsb", {31'd0, vld_l}, {31'd0, m_have});
        chk("busy_msb", {31'd0, busy_m}, {31'd0, m_have});
        chk("busy_lsb", {31'd0, busy_l}, {31'd0, m_have});
        chk("words_msb", {16'd0, ws_m}, m_words & 32'hFFFF);
        chk("words_lsb", {16'd0, ws_l}, m_words & 32'hFFFF);
        chk("next_msb", {31'd0, next_m}, {31'd0, exp_next()});
        chk("next_lsb", {31'd0, next_l}, {31'd0, exp_next()});
        if (m_have) begin
            chk("byte_msb", {24'd0, out_m}, {24'd0, m_word[8*(NB-1-m_k) +: 8]});
            chk("byte_lsb", {24'd0, out_l}, {24'd0, m_word[8*m_k +: 8]});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [7:0] exp_m [27] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4,
                               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                               8'hA1, 8'hB2, 8'hC3, 8'hD4,
                               8'hA1, 8'hB2, 8'h55, 8'h66, 8'h77, 8'h88,
                               8'hA1, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp_l [27] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1,
                               8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                               8'hD4, 8'hC3, 8'hB2, 8'hA1,
                               8'hD4, 8'hC3, 8'h88, 8'h77, 8'h66, 8'h55,
                               8'hD4, 8'h44, 8'h33, 8'h22, 8'h11};

    initial begin
        rst_n = 1'b0;
        byte_ready = 1'b1;
        flush = 1'b0;
        step(2);

        // reset state, with a word already waiting
        push(32'hA1B2C3D4);
        #1;
        chk("rst_valid", {31'd0, vld_m}, 32'd0);
        chk("rst_byte", {24'd0, out_m}, 32'h00);
        chk("rst_words", {16'd0, ws_m}, 32'd0);
        chk("rst_busy", {31'd0, busy_m}, 32'd0);
        chk("rst_next", {31'd0, next_m}, 32'd0);
        step(1);
        rst_n = 1'b1;

        // single word
        step(7);
        chk("t1_words", {16'd0, ws_m}, 32'd1);
        chk("t1_valid", {31'd0, vld_m}, 32'd0);
        chk("t1_pops", dut_pops, 32'd1);

        // two words back to back
        push(32'h11223344);
        push(32'h55667788);
        step(12);
        chk("t3_words", {16'd0, ws_m}, 32'd3);
        chk("t3_pops", dut_pops, 32'd3);

        // backpressure while B2 is presented
        push(32'hA1B2C3D4);
        step(2);
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("bp_byte_msb", {24'd0, out_m}, 32'hB2);
            chk("bp_byte_lsb", {24'd0, out_l}, 32'hC3);
            chk("bp_valid", {31'd0, vld_m}, 32'd1);
        end
        byte_ready = 1'b1;
        step(6);
        chk("t4_words", {16'd0, ws_m}, 32'd4);
        chk("t4_pops", dut_pops, 32'd4);

        // flush while C3 is presented, next word follows
        push(32'hA1B2C3D4);
        push(32'h55667788);
        step(3);
        flush = 1'b1;
        #1;
        chk("fl_next", {31'd0, next_m}, 32'd0);
        chk("fl_byte", {24'd0, out_m}, 32'hC3);
        step(1);
        flush = 1'b0;
        chk("fl_valid", {31'd0, vld_m}, 32'd0);
        chk("fl_busy", {31'd0, busy_m}, 32'd0);
        chk("fl_words", {16'd0, ws_m}, 32'd4);
        step(7);
        chk("t5_words", {16'd0, ws_m}, 32'd5);
        chk("t5_pops", dut_pops, 32'd6);

        // asynchronous reset mid-word
        push(32'hA1B2C3D4);
        push(32'h11223344);
        step(2);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, vld_m}, 32'd0);
        chk("ar_busy", {31'd0, busy_m}, 32'd0);
        chk("ar_byte", {24'd0, out_m}, 32'h00);
        chk("ar_words", {16'd0, ws_m}, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(7);
        chk("t6_words", {16'd0, ws_m}, 32'd1);
        chk("t6_pops", dut_pops, 32'd8);

        // accepted byte stream against hand-written order
        chk("log_len", log_m.size(), 32'd27);
        if (log_m.size() == 27) begin
            for (int i = 0; i < 27; i++) begin
                chk("log_msb", {24'd0, log_m[i]}, {24'd0, exp_m[i]});
                chk("log_lsb", {24'd0, log_l[i]}, {24'd0, exp_l[i]});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
